// File: rtl/regs_mp.sv
// Integer register file: NRD combinational core read ports, one write port, one registered bus read port.
// Optional same-cycle write-through forwarding on core reads is enabled by defining REGS_BYPASS_EN.
module regs_mp #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic                clr_i,
  output logic                busy_o,
  input  logic                bus_re_i,
  input  logic [AW-1:0]       bus_raddr_i,
  output logic [XLEN-1:0]     bus_rdata_o,
  output logic                bus_rvalid_o
);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t          state;
  logic [AW-1:0]   idx;
  logic            busy_q;
  logic            clearing;

  logic [XLEN-1:0] regs [NREG];

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  logic            bus_vld_p1;
  logic [XLEN-1:0] bus_rdata_p1;

  assign clearing = (state == S_CLEAR);
  assign busy_o   = busy_q;

  // Clear engine: walks idx from 1 to NREG-1, one register per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_CLEAR;
      idx    <= AW'(1);
      busy_q <= 1'b1;
    end else begin
      case (state)
        S_CLEAR: begin
          idx <= idx + AW'(1);
          if (idx == AW'(NREG - 1)) begin
            state  <= S_READY;
            busy_q <= 1'b0;
          end
        end
        S_READY: begin
          if (clr_i) begin
            state  <= S_CLEAR;
            idx    <= AW'(1);
            busy_q <= 1'b1;
          end
        end
        default: begin
          state  <= S_CLEAR;
          idx    <= AW'(1);
          busy_q <= 1'b1;
        end
      endcase
    end
  end

  // Single physical write port shared by the clear engine and the core; clear takes priority.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = waddr_i;
    wr_data = wdata_i;
    if (clearing) begin
      wr_en   = 1'b1;
      wr_addr = idx;
      wr_data = '0;
    end else if (we_i && (waddr_i != '0) && !clr_i) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  function automatic logic [XLEN-1:0] core_read(input logic [AW-1:0] ra);
    logic [XLEN-1:0] rd;
    rd = '0;
    if (!clearing && (ra != '0)) begin
      rd = regs[ra];
`ifdef REGS_BYPASS_EN
      if (we_i && (waddr_i != '0) && (ra == waddr_i)) begin
        rd = wdata_i;
      end
`endif
    end
    return rd;
  endfunction

  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < NRD; k++) begin
      rdata_o[k*XLEN +: XLEN] = core_read(raddr_i[k*AW +: AW]);
    end
  end

  // Bus read stage p1: captures pre-write contents at the request edge, holds between requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_vld_p1   <= 1'b0;
      bus_rdata_p1 <= '0;
    end else begin
      bus_vld_p1 <= bus_re_i;
      if (bus_re_i) begin
        bus_rdata_p1 <= (clearing || (bus_raddr_i == '0)) ? '0 : regs[bus_raddr_i];
      end
    end
  end

  assign bus_rdata_o  = bus_rdata_p1;
  assign bus_rvalid_o = bus_vld_p1;

endmodule

// File: tb/tb_regs_mp.sv
// Directed bench for regs_mp (default parameters); expectations follow REGS_BYPASS_EN if defined.
module tb_regs_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk;
  logic                rst;
  logic [NRD*AW-1:0]   raddr_i;
  logic [NRD*XLEN-1:0] rdata_o;
  logic                we_i;
  logic [AW-1:0]       waddr_i;
  logic [XLEN-1:0]     wdata_i;
  logic                clr_i;
  logic                busy_o;
  logic                bus_re_i;
  logic [AW-1:0]       bus_raddr_i;
  logic [XLEN-1:0]     bus_rdata_o;
  logic                bus_rvalid_o;

  int checks = 0;
  int errors = 0;

  regs_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .raddr_i(raddr_i), .rdata_o(rdata_o),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .clr_i(clr_i),
    .busy_o(busy_o), .bus_re_i(bus_re_i), .bus_raddr_i(bus_raddr_i),
    .bus_rdata_o(bus_rdata_o), .bus_rvalid_o(bus_rvalid_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raddr(input int a0, input int a1);
    raddr_i = {AW'(a1), AW'(a0)};
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || bus_rvalid_o !== 1'b0 || bus_rdata_o !== '0) begin
      errors++;
      $display("FAIL reset_state busy=%b rvalid=%b rdata=%h expected busy=1 rvalid=0 rdata=0",
               busy_o, bus_rvalid_o, bus_rdata_o);
    end
    cnt = 0;
    while (busy_o && cnt < 100) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt !== 31) begin
      errors++;
      $display("FAIL reset_busy_len got %0d expected 31", cnt);
    end
    for (int a = 1; a < NREG; a++) begin
      set_raddr(a, a);
      #1;
      checks++;
      if (rdata_o !== '0) begin
        errors++;
        $display("FAIL reset_zero x%0d got %h expected 0", a, rdata_o);
      end
    end
  endtask

  task automatic test_write();
    we_i = 1'b1; waddr_i = 5; wdata_i = 32'hDEADBEEF;
    tick();
    we_i = 1'b0;
    set_raddr(5, 5);
    #1;
    checks++;
    if (rdata_o !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL write_x5 got %h expected deadbeefdeadbeef", rdata_o);
    end
    we_i = 1'b1; waddr_i = 0; wdata_i = 32'h1234;
    tick();
    we_i = 1'b0;
    set_raddr(0, 5);
    #1;
    checks++;
    if (rdata_o !== {32'hDEADBEEF, 32'h0}) begin
      errors++;
      $display("FAIL write_x0 got %h expected deadbeef00000000", rdata_o);
    end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] exp_same;
`ifdef REGS_BYPASS_EN
    exp_same = 32'hA5A5A5A5;
`else
    exp_same = 32'h0;
`endif
    we_i = 1'b1; waddr_i = 7; wdata_i = 32'hA5A5A5A5;
    set_raddr(7, 5);
    #1;
    checks++;
    if (rdata_o !== {32'hDEADBEEF, exp_same}) begin
      errors++;
      $display("FAIL bypass_same_cycle got %h expected %h", rdata_o, {32'hDEADBEEF, exp_same});
    end
    tick();
    we_i = 1'b0;
    set_raddr(7, 7);
    #1;
    checks++;
    if (rdata_o !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
      errors++;
      $display("FAIL bypass_next_cycle got %h expected a5a5a5a5a5a5a5a5", rdata_o);
    end
  endtask

  task automatic test_bus();
    we_i = 1'b1; waddr_i = 9; wdata_i = 32'h99;
    tick();
    we_i = 1'b0;
    bus_re_i = 1'b1; bus_raddr_i = 9;
    tick();
    bus_re_i = 1'b0;
    checks++;
    if (bus_rvalid_o !== 1'b1 || bus_rdata_o !== 32'h99) begin
      errors++;
      $display("FAIL bus_read rvalid=%b data=%h expected 1 00000099", bus_rvalid_o, bus_rdata_o);
    end
    tick();
    checks++;
    if (bus_rvalid_o !== 1'b0 || bus_rdata_o !== 32'h99) begin
      errors++;
      $display("FAIL bus_hold rvalid=%b data=%h expected 0 00000099", bus_rvalid_o, bus_rdata_o);
    end
    bus_re_i = 1'b1; bus_raddr_i = 9;
    we_i = 1'b1; waddr_i = 9; wdata_i = 32'h100;
    tick();
    bus_re_i = 1'b0; we_i = 1'b0;
    set_raddr(9, 9);
    #1;
    checks++;
    if (bus_rvalid_o !== 1'b1 || bus_rdata_o !== 32'h99 || rdata_o !== {32'h100, 32'h100}) begin
      errors++;
      $display("FAIL bus_prewrite rvalid=%b data=%h core=%h expected 1 00000099 core 0000010000000100",
               bus_rvalid_o, bus_rdata_o, rdata_o);
    end
    bus_re_i = 1'b1; bus_raddr_i = 5;
    tick();
    checks++;
    if (bus_rvalid_o !== 1'b1 || bus_rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bus_b2b_first rvalid=%b data=%h expected 1 deadbeef", bus_rvalid_o, bus_rdata_o);
    end
    bus_raddr_i = 0;
    tick();
    bus_re_i = 1'b0;
    checks++;
    if (bus_rvalid_o !== 1'b1 || bus_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL bus_b2b_x0 rvalid=%b data=%h expected 1 00000000", bus_rvalid_o, bus_rdata_o);
    end
    tick();
  endtask

  task automatic test_clear();
    int cnt;
    for (int a = 1; a < NREG; a++) begin
      we_i = 1'b1; waddr_i = AW'(a); wdata_i = XLEN'(a);
      tick();
    end
    we_i = 1'b0;
    set_raddr(31, 3);
    #1;
    checks++;
    if (rdata_o !== {32'd3, 32'd31}) begin
      errors++;
      $display("FAIL clear_fill got %h expected 000000030000001f", rdata_o);
    end
    clr_i = 1'b1; we_i = 1'b1; waddr_i = 3; wdata_i = 32'hFF;
    tick();
    clr_i = 1'b0;
    cnt = 0;
    while (busy_o && cnt < 100) begin
      bus_re_i = (cnt == 0); bus_raddr_i = 31;
      we_i = 1'b1; waddr_i = 1; wdata_i = 32'h77;
      set_raddr(31, 31);
      #1;
      if (cnt == 0) begin
        checks++;
        if (rdata_o !== '0) begin
          errors++;
          $display("FAIL clear_core_read got %h expected 0", rdata_o);
        end
      end
      tick();
      cnt++;
      if (cnt == 1) begin
        checks++;
        if (bus_rvalid_o !== 1'b1 || bus_rdata_o !== '0) begin
          errors++;
          $display("FAIL clear_bus_read rvalid=%b data=%h expected 1 00000000", bus_rvalid_o, bus_rdata_o);
        end
      end
    end
    we_i = 1'b0; bus_re_i = 1'b0;
    checks++;
    if (cnt !== 31) begin
      errors++;
      $display("FAIL clear_busy_len got %0d expected 31", cnt);
    end
    for (int a = 1; a < NREG; a++) begin
      set_raddr(a, a);
      #1;
      checks++;
      if (rdata_o !== '0) begin
        errors++;
        $display("FAIL clear_zero x%0d got %h expected 0", a, rdata_o);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    we_i = 1'b1; waddr_i = 20; wdata_i = 32'h2020;
    tick();
    we_i = 1'b0;
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL midclr_busy got %b expected 1", busy_o);
    end
    cnt = 0;
    while (busy_o && cnt < 100) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt !== 31) begin
      errors++;
      $display("FAIL midclr_len got %0d expected 31", cnt);
    end
    set_raddr(20, 1);
    #1;
    checks++;
    if (rdata_o !== '0) begin
      errors++;
      $display("FAIL midclr_zero got %h expected 0", rdata_o);
    end
  endtask

  initial begin
    rst = 1'b1; raddr_i = '0; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    clr_i = 1'b0; bus_re_i = 1'b0; bus_raddr_i = '0;
    test_reset();
    test_write();
    test_bypass();
    test_bus();
    test_clear();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
